// File: rtl/lc_line_responder.sv
// Line responder on the lc_* interface: serves 512-bit line reads after a fixed latency and absorbs writebacks.
// Optional LC_WRITE_ACK_EN: accepted writes also return an acknowledge response (written line + aligned address).
module lc_line_responder #(
  parameter int LINE_BITS   = 512,
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4,
  parameter int ADDR_BITS   = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 cs_N_in,
  input  logic                 l1_valid_in,
  output logic                 l1_ready_out,
  input  logic [ADDR_BITS-1:0] l1_addr_in,
  input  logic [LINE_BITS-1:0] l1_value_in,
  input  logic                 l1_we_in,
  output logic                 l1_valid_out,
  input  logic                 l1_ready_in,
  output logic [ADDR_BITS-1:0] l1_addr_out,
  output logic [LINE_BITS-1:0] l1_value_out,
  output logic                 busy_out,
  output logic [1:0]           state_out
);

  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef LC_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_BITS-1:0]    cnt;
  logic [LINE_BITS-1:0]   mem [DEPTH_LINES];
  logic [IDX_BITS-1:0]    idx;
  logic [ADDR_BITS-1:0]   aligned_addr;
  logic                   accept;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Request side: ready depends only on state and chip select, never on valid.
  // Response side: valid, addr and value stay frozen until the edge where ready_in is seen high.
  assign l1_ready_out = rst_N_in && (state == ST_IDLE) && !cs_N_in;
  assign accept       = l1_valid_in && l1_ready_out;
  assign idx          = l1_addr_in[IDX_BITS+5:6];
  assign aligned_addr = {l1_addr_in[ADDR_BITS-1:6], 6'b0};
  assign state_out    = state;

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < DEPTH_LINES; i++) mem[i] <= '0;
    end else if (accept && l1_we_in) begin
      mem[idx] <= l1_value_in;
    end
  end

  // The counter holds the remaining WAIT edges; RESP is entered LATENCY edges after the accept.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      l1_valid_out <= 1'b0;
      l1_addr_out  <= '0;
      l1_value_out <= '0;
      busy_out     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (!l1_we_in || WR_ACK)) begin
            l1_addr_out  <= aligned_addr;
            l1_value_out <= l1_we_in ? l1_value_in : mem[idx];
            cnt          <= CNT_BITS'(LATENCY - 1);
            busy_out     <= 1'b1;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state        <= ST_RESP;
            l1_valid_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (l1_ready_in) begin
            state        <= ST_IDLE;
            l1_valid_out <= 1'b0;
            busy_out     <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          l1_valid_out <= 1'b0;
          busy_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc_line_responder.sv
// Bench for lc_line_responder: transaction-level model with an expected-response queue, directed cases, random traffic.
module tb_lc_line_responder;
  localparam int LB  = 512;
  localparam int AB  = 64;
  localparam int LAT = 4;
  localparam int DEP = 64;

  logic          clk_in = 1'b0;
  logic          rst_N_in;
  logic          cs_N_in;
  logic          l1_valid_in;
  logic          l1_ready_out;
  logic [AB-1:0] l1_addr_in;
  logic [LB-1:0] l1_value_in;
  logic          l1_we_in;
  logic          l1_valid_out;
  logic          l1_ready_in;
  logic [AB-1:0] l1_addr_out;
  logic [LB-1:0] l1_value_out;
  logic          busy_out;
  logic [1:0]    state_out;

  lc_line_responder #(.LINE_BITS(LB), .DEPTH_LINES(DEP), .LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_N_in(cs_N_in),
    .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out),
    .l1_addr_in(l1_addr_in), .l1_value_in(l1_value_in), .l1_we_in(l1_we_in),
    .l1_valid_out(l1_valid_out), .l1_ready_in(l1_ready_in),
    .l1_addr_out(l1_addr_out), .l1_value_out(l1_value_out),
    .busy_out(busy_out), .state_out(state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- model state ----------------
  logic [LB+AB-1:0] exp_q[$];        // pending response {addr, line}
  logic [LB-1:0]    mdl_mem [int];   // lines written since reset; absent means zero
  int               cyc = 0;
  int               due = 0;
  int               k;
  logic [AB-1:0]    m_aligned;
  logic [LB-1:0]    m_line;
  logic             m_resp_visible;
  logic [LB-1:0]    a5_line;
  logic [LB-1:0]    pat1;
  logic [LB-1:0]    pat2;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] r;
    for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Transaction model: one outstanding response at most, visible LAT edges after its accept.
  initial forever begin
    @(posedge clk_in or negedge rst_N_in);
    if (!rst_N_in) begin
      exp_q.delete();
      mdl_mem.delete();
      cyc = 0;
      due = 0;
    end else begin
      m_resp_visible = (exp_q.size() > 0) && (cyc >= due);
      if (m_resp_visible && l1_ready_in) begin
        void'(exp_q.pop_front());
      end else if (exp_q.size() == 0 && l1_valid_in && !cs_N_in) begin
        k         = int'((l1_addr_in >> 6) % DEP);
        m_aligned = l1_addr_in & ~64'h3f;
        if (l1_we_in) begin
          mdl_mem[k] = l1_value_in;
`ifdef LC_WRITE_ACK_EN
          exp_q.push_back({m_aligned, l1_value_in});
          due = cyc + 1 + LAT;
`endif
        end else begin
          m_line = mdl_mem.exists(k) ? mdl_mem[k] : '0;
          exp_q.push_back({m_aligned, m_line});
          due = cyc + 1 + LAT;
        end
      end
      cyc++;
    end
  end

  // ---------------- scoreboard compare, every cycle on the falling edge ----------------
  initial forever begin
    @(negedge clk_in);
    if (!rst_N_in) begin
      check("rst_ready", l1_ready_out, 0);
      check("rst_valid", l1_valid_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_addr", l1_addr_out, 0);
      check("rst_value", l1_value_out, 0);
    end else begin
      m_resp_visible = (exp_q.size() > 0) && (cyc >= due);
      check("ready", l1_ready_out, (exp_q.size() == 0) && !cs_N_in);
      check("valid", l1_valid_out, m_resp_visible);
      check("busy", busy_out, exp_q.size() > 0);
      if (m_resp_visible) begin
        check("resp_addr", l1_addr_out, exp_q[0][LB +: AB]);
        check("resp_value", l1_value_out, exp_q[0][LB-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!l1_valid_out && n < 50) begin
      step();
      n++;
    end
    if (!l1_valid_out) check("resp_timeout", 0, 1);
  endtask

  task automatic do_handshake();
    l1_ready_in = 1'b1;
    step();
    l1_ready_in = 1'b0;
    check("post_hs_valid", l1_valid_out, 0);
    check("post_hs_busy", busy_out, 0);
  endtask

  task automatic do_write(input logic [AB-1:0] a, input logic [LB-1:0] v);
    int n;
    l1_valid_in = 1'b1; l1_we_in = 1'b1; l1_addr_in = a; l1_value_in = v;
    step();
    l1_valid_in = 1'b0; l1_we_in = 1'b0; l1_value_in = '0;
`ifdef LC_WRITE_ACK_EN
    wait_valid(n);
    check("wack_latency", n, LAT);
    check("wack_value", l1_value_out, v);
    do_handshake();
`else
    n = 0;
    check("wr_no_busy", busy_out, 0);
    check("wr_no_valid", l1_valid_out, 0);
    check("wr_ready", l1_ready_out, 1);
`endif
  endtask

  task automatic do_read(input logic [AB-1:0] a, input logic [LB-1:0] exp_v,
                         input logic [AB-1:0] exp_a, input int hold);
    int n;
    l1_valid_in = 1'b1; l1_we_in = 1'b0; l1_addr_in = a;
    step();
    l1_valid_in = 1'b0;
    wait_valid(n);
    check("rd_latency", n, LAT);
    check("rd_addr", l1_addr_out, exp_a);
    check("rd_value", l1_value_out, exp_v);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", l1_valid_out, 1);
      check("hold_addr", l1_addr_out, exp_a);
      check("hold_value", l1_value_out, exp_v);
      check("hold_ready", l1_ready_out, 0);
    end
    do_handshake();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_N_in = 1'b0; cs_N_in = 1'b0; l1_valid_in = 1'b0; l1_we_in = 1'b0;
    l1_addr_in = '0; l1_value_in = '0; l1_ready_in = 1'b0;
    a5_line = {64{8'hA5}};
    pat1 = rnd_line();
    pat2 = rnd_line();
    repeat (3) @(posedge clk_in);
    check("in_rst_ready", l1_ready_out, 0);
    #1 rst_N_in = 1'b1;
    #1 check("after_rst_ready", l1_ready_out, 1);
    step();

    // Cold read returns zero, aligned address.
    do_read(64'h40, '0, 64'h40, 0);
    // Write with byte offset, read aligned.
    do_write(64'h1C7, a5_line);
    do_read(64'h1C0, a5_line, 64'h1C0, 0);
    // Backpressure: response frozen for 10 cycles.
    do_read(64'h1C0, a5_line, 64'h1C0, 10);
    // Upper address bits alias onto index 0.
    do_write(64'h1000, pat1);
    do_read(64'h0, pat1, 64'h0, 0);

    // Chip select high blocks accepts.
    cs_N_in = 1'b1; l1_valid_in = 1'b1; l1_addr_in = 64'h1C0;
    repeat (3) begin
      step();
      check("cs_ready", l1_ready_out, 0);
      check("cs_busy", busy_out, 0);
    end
    l1_valid_in = 1'b0; cs_N_in = 1'b0;
    step();
    // Chip select rising mid-WAIT still delivers the pending response.
    l1_valid_in = 1'b1; l1_addr_in = 64'h1C0;
    step();
    l1_valid_in = 1'b0;
    step();
    cs_N_in = 1'b1;
    wait_valid(n);
    check("cs_mid_value", l1_value_out, a5_line);
    do_handshake();
    check("cs_hi_idle_ready", l1_ready_out, 0);
    cs_N_in = 1'b0;
    step();

    // Reset during WAIT drops the read and clears the store.
    do_write(64'h80, pat2);
    l1_valid_in = 1'b1; l1_addr_in = 64'h80;
    step();
    l1_valid_in = 1'b0;
    step();
    rst_N_in = 1'b0;
    #1;
    check("mid_rst_valid", l1_valid_out, 0);
    check("mid_rst_busy", busy_out, 0);
    step();
    rst_N_in = 1'b1;
    step();
    do_read(64'h80, '0, 64'h80, 0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      l1_valid_in = 1'($urandom_range(0, 1));
      l1_we_in    = 1'($urandom_range(0, 1));
      cs_N_in     = ($urandom_range(0, 7) == 0);
      l1_ready_in = 1'($urandom_range(0, 1));
      l1_addr_in  = ({$urandom, $urandom} & ~64'hFC0) | (64'($urandom_range(0, 3)) << 6);
      l1_value_in = rnd_line();
      step();
    end
    l1_valid_in = 1'b0; cs_N_in = 1'b0; l1_ready_in = 1'b1;
    repeat (LAT + 4) step();
    l1_ready_in = 1'b0;
    step();
    check("drain_busy", busy_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
